imm_packer: RTL and testbench
=============================

// Module: imm_packer
// PURPOSE
//  Inverse of the immediate extender: packs a 32-bit immediate plus register/funct/opcode fields
//  into a 32-bit RV32I instruction word for I/S/B/J/U formats. Used by the boot-ROM/test-program
//  generator and the extender round-trip self-check.
//  2-stage valid/ready pipeline with range/alignment checking of the immediate.
// PARAMETERS
//  ERR_CNT_W  8  width of saturating error counter (used only when IMM_RANGE_CHECK_EN defined)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   input request valid
//  in_ready   out  1   block accepts request this cycle
//  imm_type   in   3   000 I, 001 S, 010 B, 011 J, 100 U; 101-111 illegal
//  imm        in   32  immediate as the extender outputs it (sign-extended / U already <<12)
//  rd,rs1,rs2 in   5   register fields (ignored where the format has none)
//  funct3     in   3   funct3 field (I/S/B only)
//  opcode     in   7   inst[6:0], passed through unchanged
//  out_valid  out  1   packed word valid
//  out_ready  in   1   consumer accepts word
//  inst_out   out  32  packed instruction word
//  out_err    out  1   immediate not representable / illegal imm_type (qualified by out_valid)
//  err_cnt    out  ERR_CNT_W  saturating count of words sent with out_err=1 (macro only)
// BEHAVIOUR
//  - Reset: s1_valid=0, s2_valid=0, out_valid=0, inst_out=0, out_err=0, err_cnt=0; in_ready=1 after reset.
//  - Handshake: transfer on valid&ready at each side; out_valid, inst_out, out_err held stable while out_valid&!out_ready.
//  - in_ready = !(s1_valid & s2_valid & !out_ready); full throughput of 1 word/cycle, no bubbles.
//  - Latency: accepted in cycle N -> out_valid in cycle N+2 when out_ready stays high.
//  - S1 registers inputs and computes err; S2 registers packed word. Order preserved, no drops/dups.
//  - Packing (opcode always [6:0]):
//     I: [31:20]=imm[11:0] [19:15]=rs1 [14:12]=funct3 [11:7]=rd
//     S: [31:25]=imm[11:5] [24:20]=rs2 [19:15]=rs1 [14:12]=funct3 [11:7]=imm[4:0]
//     B: [31]=imm[12] [30:25]=imm[10:5] [24:20]=rs2 [19:15]=rs1 [14:12]=funct3 [11:8]=imm[4:1] [7]=imm[11]
//     J: [31]=imm[20] [30:21]=imm[10:1] [20]=imm[11] [19:12]=imm[19:12] [11:7]=rd
//     U: [31:12]=imm[31:12] [11:7]=rd
//     illegal type: inst_out=32'h0000_0000, out_err=1 (regardless of macro)
//  - Out-of-range immediates are truncated per the table above; never saturated.
//  - Reset mid-operation: all in-flight words discarded, nothing emitted after rst deasserts until new input.
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined: out_err also set when I/S imm[31:11] not all equal; B imm[31:12] not
//   all equal or imm[0]=1; J imm[31:20] not all equal or imm[0]=1; U imm[11:0]!=0.
//   err_cnt increments on each out_valid&out_ready&out_err, saturates at all-ones.
//  Not defined: out_err only for illegal imm_type; err_cnt port absent; no counter logic.
// STRUCTURE
//  Package riscv_imm_pkg: IMM_I/S/B/J/U type constants, OPC_* opcode constants, field position
//   localparams; shared with the extender.
//  Sub-module imm_field_mux: combinational format packer (type, imm, fields -> word); instantiated in S2.
// TESTING
//  1 I: imm=32'hFFFF_FFFF rd=1 rs1=2 f3=0 op=7'h13 -> inst_out=32'hFFF1_0093, out_err=0, 2 cycles later.
//  2 S: imm=8 rs2=5 rs1=2 f3=2 op=7'h23 -> 32'h0051_2423; B: imm=-4 rs1=rs2=0 f3=0 op=7'h63 -> 32'hFE00_0EE3.
//  3 J: imm=32'h800 rd=1 op=7'h6F -> 32'h0010_00EF; U: imm=32'h1234_5000 rd=5 op=7'h37 -> 32'h1234_52B7.
//  4 Range (macro on): I imm=2048 -> out_err=1, inst_out=32'h8000_0000|fields, err_cnt 0->1; B imm=6 ok, imm=5 -> err.
//  5 Backpressure: 4 back-to-back inputs, out_ready low 3 cycles -> in_ready low after 2 accepted, words
//    emerge in order, held stable; imm_type=3'b111 -> inst_out=0, out_err=1.
//  6 Round-trip: random legal imm/type -> feed inst_out[31:7] to the extender, ImmOut/Imm_U == imm; rst mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/riscv_imm_pkg.sv
// RV32I immediate-format constants shared by the immediate extender and imm_packer.
// Holds format codes, common opcodes, field positions and the representability check.
package riscv_imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;

  // True when the immediate cannot be encoded exactly in the given format.
  function automatic logic imm_out_of_range(input logic [2:0] imm_type, input logic [31:0] imm);
    case (imm_type)
      IMM_I, IMM_S: return !((&imm[31:11]) || !(|imm[31:11]));
      IMM_B:        return !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      IMM_J:        return !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      IMM_U:        return |imm[11:0];
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_field_mux.sv
// Combinational RV32I format packer: scatters immediate bits and register fields into a word.
// Illegal format codes produce an all-zero word.
module imm_field_mux
  import riscv_imm_pkg::*;
(
  input  logic [2:0]  imm_type_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  opcode_i,
  output logic [31:0] inst_o
);

  // NOTE: the whole word is defaulted before the case so no path leaves a bit unassigned (no latch).
  always_comb begin
    inst_o = '0;
    case (imm_type_i)
      IMM_I: begin
        inst_o[31:20]            = imm_i[11:0];
        inst_o[RS1_LSB +: 5]     = rs1_i;
        inst_o[F3_LSB +: 3]      = funct3_i;
        inst_o[RD_LSB +: 5]      = rd_i;
        inst_o[OPC_LSB +: 7]     = opcode_i;
      end
      IMM_S: begin
        inst_o[31:25]            = imm_i[11:5];
        inst_o[RS2_LSB +: 5]     = rs2_i;
        inst_o[RS1_LSB +: 5]     = rs1_i;
        inst_o[F3_LSB +: 3]      = funct3_i;
        inst_o[11:7]             = imm_i[4:0];
        inst_o[OPC_LSB +: 7]     = opcode_i;
      end
      IMM_B: begin
        inst_o[31]               = imm_i[12];
        inst_o[30:25]            = imm_i[10:5];
        inst_o[RS2_LSB +: 5]     = rs2_i;
        inst_o[RS1_LSB +: 5]     = rs1_i;
        inst_o[F3_LSB +: 3]      = funct3_i;
        inst_o[11:8]             = imm_i[4:1];
        inst_o[7]                = imm_i[11];
        inst_o[OPC_LSB +: 7]     = opcode_i;
      end
      IMM_J: begin
        inst_o[31]               = imm_i[20];
        inst_o[30:21]            = imm_i[10:1];
        inst_o[20]               = imm_i[11];
        inst_o[19:12]            = imm_i[19:12];
        inst_o[RD_LSB +: 5]      = rd_i;
        inst_o[OPC_LSB +: 7]     = opcode_i;
      end
      IMM_U: begin
        inst_o[31:12]            = imm_i[31:12];
        inst_o[RD_LSB +: 5]      = rd_i;
        inst_o[OPC_LSB +: 7]     = opcode_i;
      end
      default: inst_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready pipeline packing an immediate and fields into an RV32I instruction word.
// Define IMM_RANGE_CHECK_EN to flag non-representable immediates and enable the err_cnt counter.
module imm_packer
  import riscv_imm_pkg::*;
`ifdef IMM_RANGE_CHECK_EN
#(
  parameter int unsigned ERR_CNT_W = 8
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_type,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  opcode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst_out,
  output logic        out_err
`ifdef IMM_RANGE_CHECK_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic        s1_valid_q;
  logic [2:0]  s1_type_q;
  logic [31:0] s1_imm_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]  s1_f3_q;
  logic [6:0]  s1_op_q;
  logic        s1_err_q, s1_err_d;

  logic        s2_valid_q;
  logic [31:0] s2_inst_q, s2_inst_d;
  logic        s2_err_q;
  logic        s2_en;

  // Stage 2 drains whenever it is empty or its word leaves this cycle.
  assign s2_en    = !s2_valid_q || out_ready;
  assign in_ready = !(s1_valid_q && s2_valid_q && !out_ready);

  always_comb begin
    s1_err_d = (imm_type > IMM_U);
`ifdef IMM_RANGE_CHECK_EN
    s1_err_d = s1_err_d || imm_out_of_range(imm_type, imm);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
    end
  end

  // NOTE: payload registers carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_type_q <= imm_type;
      s1_imm_q  <= imm;
      s1_rd_q   <= rd;
      s1_rs1_q  <= rs1;
      s1_rs2_q  <= rs2;
      s1_f3_q   <= funct3;
      s1_op_q   <= opcode;
      s1_err_q  <= s1_err_d;
    end
  end

  imm_field_mux u_field_mux (
    .imm_type_i (s1_type_q),
    .imm_i      (s1_imm_q),
    .rd_i       (s1_rd_q),
    .rs1_i      (s1_rs1_q),
    .rs2_i      (s1_rs2_q),
    .funct3_i   (s1_f3_q),
    .opcode_i   (s1_op_q),
    .inst_o     (s2_inst_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_inst_q <= s2_inst_d;
        s2_err_q  <= s1_err_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign inst_out  = s2_inst_q;
  assign out_err   = s2_err_q;

`ifdef IMM_RANGE_CHECK_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (s2_valid_q && out_ready && s2_err_q && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Directed bench for imm_packer: format packing, latency, backpressure, reset flush, round-trip.
// Range-error expectations follow IMM_RANGE_CHECK_EN when the bench is built with it.
module tb_imm_packer;
  import riscv_imm_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  op;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_type;
  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_out;
  logic        out_err;
`ifdef IMM_RANGE_CHECK_EN
  logic [7:0]  err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_errs = 0;

  imm_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_type  (imm_type),
    .imm       (imm),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst_out  (inst_out),
    .out_err   (out_err)
`ifdef IMM_RANGE_CHECK_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    imm_type = v.t;
    imm      = v.imm;
    rd       = v.rd;
    rs1      = v.rs1;
    rs2      = v.rs2;
    funct3   = v.f3;
    opcode   = v.op;
  endtask

  function automatic vec_t mk(input logic [2:0] t, input logic [31:0] i, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f,
                              input logic [6:0] o);
    vec_t v;
    v.t = t; v.imm = i; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.f3 = f; v.op = o;
    return v;
  endfunction

  // Reference immediate extender (decode direction), used only for the round-trip.
  function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] w);
    case (t)
      IMM_I:   return {{20{w[31]}}, w[31:20]};
      IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {w[31:12], 12'b0};
    endcase
  endfunction

  // One request/response with out_ready high; reports the word seen.
  task automatic send_recv(input string tag, input vec_t v, output logic [31:0] inst,
                           output logic err, output bit seen);
    int waited;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    inst = '0;
    err  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        inst = inst_out;
        err  = out_err;
      end
    end
    check({tag, " out_valid"}, 32'(seen), 1);
  endtask

  task automatic run_one(input string tag, input vec_t v, input logic [31:0] exp_inst,
                         input logic exp_err);
    logic [31:0] inst;
    logic        err;
    bit          seen;
    send_recv(tag, v, inst, err, seen);
    check({tag, " inst"}, inst, exp_inst);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    if (exp_err) exp_errs++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        bp [4];
    logic [31:0] bp_inst [4];
    logic        bp_err [4];
    int          acc, got;
    bit          rdy, any_valid;
    logic [31:0] rt_inst, r, rt_imm;
    logic        rt_err;
    bit          rt_seen;
    logic [2:0]  t;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(IMM_I, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset inst_out", inst_out, 0);
    check("reset out_err", 32'(out_err), 0);
    check("reset in_ready", 32'(in_ready), 1);
`ifdef IMM_RANGE_CHECK_EN
    check("reset err_cnt", 32'(err_cnt), 0);
`endif

    // Latency: accepted at edge N, visible two edges later.
    drive(mk(IMM_I, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd0, 3'd0, OPC_OP_IMM));
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("lat N+1 out_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("lat N+2 out_valid", 32'(out_valid), 1);
    check("lat I inst", inst_out, 32'hFFF1_0093);
    check("lat I err", 32'(out_err), 0);

    run_one("S", mk(IMM_S, 32'd8, 5'd0, 5'd2, 5'd5, 3'd2, OPC_STORE), 32'h0051_2423, 1'b0);
    run_one("B", mk(IMM_B, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd0, 3'd0, OPC_BRANCH), 32'hFE00_0EE3, 1'b0);
    run_one("J", mk(IMM_J, 32'h0000_0800, 5'd1, 5'd0, 5'd0, 3'd0, OPC_JAL), 32'h0010_00EF, 1'b0);
    run_one("U", mk(IMM_U, 32'h1234_5000, 5'd5, 5'd0, 5'd0, 3'd0, OPC_LUI), 32'h1234_52B7, 1'b0);

    // Out-of-range immediates are truncated; flagged only with range checking built in.
    run_one("I 2048", mk(IMM_I, 32'd2048, 5'd1, 5'd2, 5'd0, 3'd0, OPC_OP_IMM), 32'h8001_0093, RC);
`ifdef IMM_RANGE_CHECK_EN
    @(negedge clk);
    check("err_cnt after I 2048", 32'(err_cnt), 32'(exp_errs));
`endif
    run_one("B 6", mk(IMM_B, 32'd6, 5'd0, 5'd0, 5'd0, 3'd0, OPC_BRANCH), 32'h0000_0363, 1'b0);
    run_one("B 5", mk(IMM_B, 32'd5, 5'd0, 5'd0, 5'd0, 3'd0, OPC_BRANCH), 32'h0000_0263, RC);

    // Backpressure: four back-to-back requests against a stalled consumer.
    bp[0] = mk(IMM_I, 32'hFFFF_FFFF, 5'd1, 5'd2, 5'd0, 3'd0, OPC_OP_IMM);
    bp[1] = mk(IMM_S, 32'd8, 5'd0, 5'd2, 5'd5, 3'd2, OPC_STORE);
    bp[2] = mk(IMM_U, 32'h1234_5000, 5'd5, 5'd0, 5'd0, 3'd0, OPC_LUI);
    bp[3] = mk(3'b111, 32'h1234_5678, 5'd3, 5'd4, 5'd6, 3'd1, OPC_OP_IMM);
    bp_inst[0] = 32'hFFF1_0093; bp_err[0] = 1'b0;
    bp_inst[1] = 32'h0051_2423; bp_err[1] = 1'b0;
    bp_inst[2] = 32'h1234_52B7; bp_err[2] = 1'b0;
    bp_inst[3] = 32'h0000_0000; bp_err[3] = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("bp hold in_ready", 32'(in_ready), 0);
        check("bp hold out_valid", 32'(out_valid), 1);
        check("bp hold inst", inst_out, bp_inst[0]);
        check("bp hold err", 32'(out_err), 0);
      end
      drive(bp[acc]);
      in_valid = 1'b1;
      rdy = in_ready;
      @(posedge clk);
      if (rdy) acc++;
    end
    check("bp accepted while stalled", acc, 2);
    #1 out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check("bp order inst", inst_out, bp_inst[got]);
        check("bp order err", 32'(out_err), 32'(bp_err[got]));
        got++;
      end
      if (acc < 4) begin
        drive(bp[acc]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) acc++;
    end
    #1 in_valid = 1'b0;
    check("bp words delivered", got, 4);
    exp_errs++;
    @(negedge clk);
    check("bp drained", 32'(out_valid), 0);
`ifdef IMM_RANGE_CHECK_EN
    check("err_cnt after bp", 32'(err_cnt), 32'(exp_errs));
`endif

    // Reset with two words in flight: both are discarded.
    out_ready = 1'b0;
    drive(mk(IMM_U, 32'hABCD_E000, 5'd7, 5'd0, 5'd0, 3'd0, OPC_AUIPC));
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("rst-mid pre out_valid", 32'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst-mid out_valid", 32'(out_valid), 0);
    check("rst-mid inst_out", inst_out, 0);
    check("rst-mid out_err", 32'(out_err), 0);
`ifdef IMM_RANGE_CHECK_EN
    check("rst-mid err_cnt", 32'(err_cnt), 0);
`endif
    any_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) any_valid = 1'b1;
    end
    check("rst-mid nothing emitted", 32'(any_valid), 0);

    // Round-trip through the reference extender with random legal immediates.
    for (int i = 0; i < 15; i++) begin
      r = $urandom;
      t = 3'(i % 5);
      case (t)
        IMM_I, IMM_S: rt_imm = {{20{r[11]}}, r[11:0]};
        IMM_B:        rt_imm = {{19{r[12]}}, r[12:1], 1'b0};
        IMM_J:        rt_imm = {{11{r[20]}}, r[20:1], 1'b0};
        default:      rt_imm = {r[31:12], 12'b0};
      endcase
      send_recv("rt", mk(t, rt_imm, 5'(r[4:0]), 5'(r[9:5]), 5'(r[14:10]), 3'(r[17:15]), OPC_OP_IMM),
                rt_inst, rt_err, rt_seen);
      check("rt imm", extend(t, rt_inst), rt_imm);
      check("rt err", 32'(rt_err), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
